// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator: MSB-first digit-serial magnitude compare with a start/busy/done handshake.
// Optional CMP_STATS_EN adds saturating result counters cnt_eq/cnt_gt/cnt_lt.
module seq_mag_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2,
  parameter int EARLY_EXIT = 1,
  parameter int CW = $clog2(WIDTH/DIGIT+1)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             greater,
  output logic             lower,
  output logic [CW-1:0]    cycles
`ifdef CMP_STATS_EN
  ,
  output logic [15:0]      cnt_eq,
  output logic [15:0]      cnt_gt,
  output logic [15:0]      cnt_lt
`endif
);
  localparam int N = WIDTH/DIGIT;
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH-1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_next;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0] cnt;
  logic [DIGIT-1:0] da, db;
  logic st_gt, st_lt, diff, last, fin, take, f_gt, f_lt;
  assign da = sa[WIDTH-1 -: DIGIT];
  assign db = sb[WIDTH-1 -: DIGIT];
  assign diff = da != db;
  assign last = cnt == CW'(N-1);
  assign fin = last || (EARLY_EXIT != 0 && diff);
  assign take = start && state != BUSY;
  // the first differing digit decides; later digits only matter if all earlier ones matched
  assign f_gt = (st_gt || st_lt) ? st_gt : da > db;
  assign f_lt = (st_gt || st_lt) ? st_lt : da < db;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_next;
  always_comb
    state_next = state == BUSY ? (fin ? DONE : BUSY) : (start ? BUSY : IDLE);
  always_comb begin
    busy = state == BUSY;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sa <= '0;
      sb <= '0;
      cnt <= '0;
      st_gt <= 1'b0;
      st_lt <= 1'b0;
      equal <= 1'b0;
      greater <= 1'b0;
      lower <= 1'b0;
      cycles <= '0;
    end else if (take) begin
      // flipping the sign bit maps two's-complement order onto unsigned order
      sa <= a ^ (signed_mode ? MSB : '0);
      sb <= b ^ (signed_mode ? MSB : '0);
      cnt <= '0;
      st_gt <= 1'b0;
      st_lt <= 1'b0;
    end else if (state == BUSY) begin
      cnt <= cnt + CW'(1);
      sa <= sa << DIGIT;
      sb <= sb << DIGIT;
      if (diff && !st_gt && !st_lt) begin
        st_gt <= da > db;
        st_lt <= da < db;
      end
      if (fin) begin
        equal <= !(f_gt || f_lt);
        greater <= f_gt;
        lower <= f_lt;
        cycles <= cnt + CW'(1);
      end
    end
  end
`ifdef CMP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_eq <= '0;
      cnt_gt <= '0;
      cnt_lt <= '0;
    end else if (state == DONE) begin
      if (equal && cnt_eq != 16'hFFFF) cnt_eq <= cnt_eq + 16'd1;
      if (greater && cnt_gt != 16'hFFFF) cnt_gt <= cnt_gt + 16'd1;
      if (lower && cnt_lt != 16'hFFFF) cnt_lt <= cnt_lt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_seq_mag_comparator.sv
// tb_seq_mag_comparator: directed vectors with a queue scoreboard and per-DUT done monitors.
module tb_seq_mag_comparator;
  logic clk = 0, rst = 1, start = 0, start0 = 0, sm = 0;
  logic [7:0] a = 0, b = 0;
  logic busy, done, equal, greater, lower, busy0, done0, equal0, greater0, lower0;
  logic [2:0] cycles, cycles0;
`ifdef CMP_STATS_EN
  logic [15:0] ce, cg, cl, ce0, cg0, cl0;
`endif
  seq_mag_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
    .busy(busy), .done(done), .equal(equal), .greater(greater), .lower(lower), .cycles(cycles)
`ifdef CMP_STATS_EN
    , .cnt_eq(ce), .cnt_gt(cg), .cnt_lt(cl)
`endif
  );
  seq_mag_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .signed_mode(sm), .a(a), .b(b),
    .busy(busy0), .done(done0), .equal(equal0), .greater(greater0), .lower(lower0), .cycles(cycles0)
`ifdef CMP_STATS_EN
    , .cnt_eq(ce0), .cnt_gt(cg0), .cnt_lt(cl0)
`endif
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic eq, gt, lt; int l; int at;} exp_t;
  exp_t q[$], q0[$];
  int checks = 0, errors = 0;
  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask
  always @(negedge clk) if (!rst && done) begin
    exp_t e;
    if (q.size() == 0) chk("dut spurious done (queue size)", q.size(), 1);
    else begin
      e = q.pop_front();
      chk("dut flags {eq,gt,lt}", {equal, greater, lower}, {e.eq, e.gt, e.lt});
      chk("dut cycles", cycles, e.l);
      chk("dut done cycle", cyc, e.at);
    end
  end
  always @(negedge clk) if (!rst && done0) begin
    exp_t e;
    if (q0.size() == 0) chk("dut0 spurious done (queue size)", q0.size(), 1);
    else begin
      e = q0.pop_front();
      chk("dut0 flags {eq,gt,lt}", {equal0, greater0, lower0}, {e.eq, e.gt, e.lt});
      chk("dut0 cycles", cycles0, e.l);
      chk("dut0 done cycle", cyc, e.at);
    end
  end
  // called just after a negedge; start is seen by the next posedge
  task automatic go(input bit which, input logic [7:0] xa, input logic [7:0] xb, input logic xsm,
                    input logic eq, input logic gt, input logic lt, input int l, input bit accept = 1);
    a = xa;
    b = xb;
    sm = xsm;
    if (which) start0 = 1; else start = 1;
    if (accept) begin
      if (which) q0.push_back('{eq, gt, lt, l, cyc + 1 + l});
      else q.push_back('{eq, gt, lt, l, cyc + 1 + l});
    end
    @(negedge clk);
    start = 0;
    start0 = 0;
  endtask
  task automatic wait_done(input bit which);
    for (int i = 0; i < 40; i++) begin
      if (which ? done0 : done) break;
      @(negedge clk);
    end
    chk(which ? "dut0 wait_done" : "dut wait_done", int'(which ? done0 : done), 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset dut outputs", {busy, done, equal, greater, lower, cycles}, 0);
    chk("reset dut0 outputs", {busy0, done0, equal0, greater0, lower0, cycles0}, 0);
    rst = 0;
    @(negedge clk);
    go(0, 8'hA5, 8'hA5, 0, 1, 0, 0, 4); wait_done(0); @(negedge clk);
    go(0, 8'h80, 8'h7F, 0, 0, 1, 0, 1); wait_done(0); @(negedge clk);
    go(0, 8'h80, 8'h7F, 1, 0, 0, 1, 1); wait_done(0); @(negedge clk);
    go(1, 8'h80, 8'h7F, 0, 0, 1, 0, 4); wait_done(1); @(negedge clk);
    go(1, 8'h80, 8'h7F, 1, 0, 0, 1, 4); wait_done(1); @(negedge clk);
    // start while busy is ignored, start on the done cycle is taken back-to-back
    go(0, 8'h10, 8'h20, 0, 0, 0, 1, 2);
    go(0, 8'hFF, 8'h00, 0, 0, 0, 0, 0, 0);
    wait_done(0);
    go(0, 8'hFF, 8'h00, 0, 0, 1, 0, 1);
    chk("back-to-back busy", busy, 1);
    wait_done(0); @(negedge clk);
    // reset in the second busy cycle aborts without a done
    go(0, 8'h00, 8'h01, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort outputs", {busy, done, equal, greater, lower, cycles}, 0);
    rst = 0;
    repeat (6) @(negedge clk);
    chk("abort stays idle", {busy, done}, 0);
    go(0, 8'h03, 8'h02, 0, 0, 1, 0, 4); wait_done(0); @(negedge clk);
    go(0, 8'hA5, 8'hA5, 0, 1, 0, 0, 4); wait_done(0); @(negedge clk);
    go(0, 8'h00, 8'h00, 0, 1, 0, 0, 4); wait_done(0); @(negedge clk);
    go(0, 8'h3C, 8'h3C, 1, 1, 0, 0, 4); wait_done(0); @(negedge clk);
    go(0, 8'h80, 8'h01, 0, 0, 1, 0, 1); wait_done(0); @(negedge clk);
    go(0, 8'h01, 8'h02, 0, 0, 0, 1, 4); wait_done(0); @(negedge clk);
`ifdef CMP_STATS_EN
    chk("cnt_eq", ce, 3);
    chk("cnt_gt", cg, 2);
    chk("cnt_lt", cl, 1);
`endif
    for (int i = 0; i < 20 && (q.size() + q0.size()) != 0; i++) @(negedge clk);
    chk("scoreboard drained", q.size() + q0.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_mag_comparator.md
Name: seq_mag_comparator

Overview:
Sequential, parametrised successor to the team's combinational WIDTH-bit comparator. Compares two operands MSB-first, DIGIT bits per clock, under a start/busy/done handshake. Supports signed or unsigned mode per operation and optional early exit on the first differing digit. Intended for wide operands where a single-cycle compare would break timing.

Parameters:
WIDTH, 8, operand width in bits; must be a multiple of DIGIT
DIGIT, 2, bits compared per clock; 1 <= DIGIT <= WIDTH
EARLY_EXIT, 1, 1 = finish on the first unequal digit; 0 = always examine all WIDTH/DIGIT digits
CW, $clog2(WIDTH/DIGIT+1), width of the cycles output

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active high
start  in  1  request; sampled only when busy=0
signed_mode  in  1  1 = two's-complement compare; captured with start
a  in  WIDTH  operand A; captured with start
b  in  WIDTH  operand B; captured with start
busy  out  1  high while a compare is in progress
done  out  1  one-cycle pulse when the result becomes valid
equal  out  1  a == b (last completed op)
greater  out  1  a > b
lower  out  1  a < b
cycles  out  CW  number of digits examined in the last op (N = WIDTH/DIGIT)

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; busy, done, equal, greater, lower = 0; cycles = 0; shift registers cleared. Takes priority over every other input, including in the middle of an operation. The aborted operation produces no done.
- States: IDLE, BUSY, DONE.
- IDLE or DONE with start=1 (edge E0):
  - Capture a and b into shift registers sa and sb.
  - If signed_mode=1, invert the MSB of both captured values. An unsigned compare then gives the signed ordering.
  - Clear the digit counter and go to BUSY.
- BUSY, each cycle:
  - Compare the top DIGIT bits of sa and sb. Increment the digit counter.
  - Digits differ and EARLY_EXIT=1: register greater/lower from the digit compare, go to DONE.
  - Digits differ and EARLY_EXIT=0: latch the first difference in internal sticky flags and continue.
  - Digits equal and not the last digit: shift sa and sb left by DIGIT and stay in BUSY.
  - Last digit: register the final result, go to DONE.
- Latency: done is high in the cycle after edge E_L, where L = digits examined.
  - EARLY_EXIT=1: 1 <= L <= N.
  - EARLY_EXIT=0: L = N.
  - cycles is updated to L together with done.
- DONE lasts exactly one cycle (done=1, busy=0), then IDLE. A start in the DONE cycle is accepted, which gives back-to-back operation with no bubble.
- busy = 1 exactly in BUSY. start while busy is ignored: no recapture, no effect on the result.
- Result flags:
  - Exactly one of equal/greater/lower is high after the first completion; all are 0 before it.
  - They hold their value until the next completion, and remain stable during BUSY.
- Operands a, b and signed_mode are don't-care except at the start-sampling edge.
- Edge case DIGIT=WIDTH: N=1, a single-cycle compare.

Optional Feature:
Macro CMP_STATS_EN.
- Defined: adds three outputs cnt_eq, cnt_gt, cnt_lt (16 bits each).
  - Each counter increments by 1 on the done cycle of the matching result.
  - Counters saturate at 16'hFFFF and are cleared by rst.
- Undefined: the ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
1. Reset: rst=1 for 2 cycles -> busy=done=equal=greater=lower=0, cycles=0.
2. WIDTH=8, DIGIT=2, EARLY_EXIT=1, unsigned, a=8'hA5, b=8'hA5 -> done 4 cycles after start; equal=1, cycles=4.
3. Same configuration, a=8'h80, b=8'h7F:
   - unsigned -> greater=1, cycles=1.
   - signed_mode=1 -> lower=1, cycles=1.
   - EARLY_EXIT=0 -> same flags, cycles=4.
4. Start a=8'h10, b=8'h20 (unsigned), then pulse start with a=8'hFF, b=8'h00 while busy -> ignored; lower=1. Then start on the done cycle with a=8'hFF, b=8'h00 -> greater=1, with no idle cycle in between.
5. Start a=8'h00, b=8'h01 (unsigned); assert rst in the 2nd BUSY cycle -> no done pulse, all outputs 0; a following start compares correctly.
6. With CMP_STATS_EN defined: run 3 equal, 2 greater and 1 lower compares -> cnt_eq=3, cnt_gt=2, cnt_lt=1. Preload near saturation -> cnt holds at 16'hFFFF.
